constraint_sampler: RTL and testbench
=====================================

Name: constraint_sampler

Overview:
- Producer side of the constraint-check interface.
- Drives packed candidate assignments (concatenated var_* buses) into an external combinational constraint checker and reads back its single-bit satisfied result.
- Candidates come from a Galois LFSR; the first satisfying candidate is returned to the solver controller over a valid/ready handshake.
- Gives up with a fail flag after MAX_TRIES rejected candidates.

Parameters:
W, 32, candidate width in bits (packed variable vector)
POLY, 32'h80200003, Galois LFSR feedback mask (W bits)
SEED, 32'h00000001, LFSR reset value; zero is replaced by 1
MAX_TRIES, 1024, attempts per start before fail; range 1..65535
CHECK_LAT, 0, cycles from cand change to valid sat; range 0..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a search (pulse), honoured only in IDLE
seed_load  input  1  load seed into LFSR, honoured only in IDLE
seed  input  W  seed value for seed_load
cand  output  W  current candidate to checker, equals LFSR register
sat  input  1  checker result for cand, valid CHECK_LAT cycles after cand changes
sol_valid  output  1  solution available
sol_ready  input  1  consumer accepts solution
sol_data  output  W  satisfying candidate
busy  output  1  state != IDLE
fail  output  1  last search exhausted MAX_TRIES; sticky until next start
tries  output  16  attempts in current or last search

Behaviour:
- Reset (async, immediate): lfsr=SEED (1 if SEED==0), state=IDLE, wait=0, sol_valid=0, sol_data=0, fail=0, tries=0, so busy=0 and cand=SEED.
- LFSR step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0). Never zero if seeded nonzero.
- States: IDLE, CHECK, HOLD.
- IDLE, seed_load=1: lfsr <= (seed==0 ? 1 : seed). A start in the same cycle is ignored.
- IDLE, start=1 (seed_load=0): tries<=0, fail<=0, wait<=CHECK_LAT, go to CHECK.
- CHECK, wait!=0: wait decrements; cand is held.
- CHECK, wait==0: sample sat and set tries<=tries+1. Then, in priority order:
  - sat=1: sol_data<=lfsr, sol_valid<=1, go to HOLD. Success wins even on attempt MAX_TRIES.
  - sat=0 and tries+1==MAX_TRIES: fail<=1, LFSR steps, go to IDLE.
  - otherwise: LFSR steps, wait<=CHECK_LAT, stay in CHECK.
- Decision rate: with CHECK_LAT=0, one candidate is decided per cycle; the first decision is on the cycle after start. With CHECK_LAT=n, one decision per n+1 cycles.
- HOLD: sol_valid=1, and sol_data/cand are stable until sol_ready=1.
  - On the handshake edge: sol_valid<=0, LFSR steps (the next search does not repeat the solution), go to IDLE.
  - sol_ready while sol_valid=0 has no effect.
- start and seed_load are ignored in CHECK and HOLD.
- tries never exceeds MAX_TRIES; it holds its final value in IDLE.
- Reset mid-CHECK or mid-HOLD: search is abandoned, sol_valid drops asynchronously, all state returns to reset values.
- sat is don't-care outside CHECK with wait==0.

Test Plan:
Common setup: W=8, POLY=8'hB8, SEED=8'h01, CHECK_LAT=0, MAX_TRIES=4. LFSR sequence from reset is 01, B8, 5C, 2E, 17, B3.
1. Reset, check values -> cand=0x01, sol_valid=0, busy=0, fail=0, tries=0. Reassert rst mid-CHECK after 2 attempts -> same values, asynchronously.
2. Checker model sat=(cand==0x2E); pulse start -> cand steps 01, B8, 5C, 2E on consecutive cycles; sol_valid=1 with sol_data=0x2E, tries=4, fail=0 (success on the last allowed attempt).
3. After reset, sat tied 0, pulse start -> after 4 decisions fail=1, busy=0, tries=4, cand=0x17. A second start clears fail and retries from 0x17.
4. Backpressure: from scenario 2, hold sol_ready=0 for 5 cycles -> sol_valid, sol_data=0x2E and cand stay stable. Raise sol_ready -> sol_valid=0 next cycle, cand=0x17, busy=0.
5. In IDLE, seed_load with seed=0x00 -> cand=0x01. seed_load with seed=0x5C plus start in the same cycle -> cand=0x5C, busy stays 0. start during CHECK -> tries not reset.
6. CHECK_LAT=2, sat=(cand==0x5C), start -> cand changes every 3 cycles; sol_valid rises 9 cycles after start with sol_data=0x5C, tries=3.

Source files
------------

// File: rtl/constraint_sampler.sv
// rtl/constraint_sampler.sv - LFSR candidate generator feeding an external constraint checker
// Returns the first satisfying candidate over a valid/ready handshake, or flags fail after MAX_TRIES.
module constraint_sampler #(
    parameter int unsigned    W         = 32,
    parameter logic [W-1:0]   POLY      = 32'h80200003,
    parameter logic [W-1:0]   SEED      = 32'h00000001,
    parameter int unsigned    MAX_TRIES = 1024,
    parameter int unsigned    CHECK_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] cand,
    input  logic         sat,
    output logic         sol_valid,
    input  logic         sol_ready,
    output logic [W-1:0] sol_data,
    output logic         busy,
    output logic         fail,
    output logic [15:0]  tries
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;
    localparam logic [15:0]  MAX_T   = 16'(MAX_TRIES);
    localparam logic [3:0]   LAT     = 4'(CHECK_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] lfsr, lfsr_nx;
    logic [3:0]   wait_cnt, wait_nx;
    logic         valid_q, valid_nx;
    logic [W-1:0] data_q, data_nx;
    logic         fail_q, fail_nx;
    logic [15:0]  tries_q, tries_nx;
    logic [15:0]  tries_inc;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED_NZ;
            wait_cnt <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            fail_q   <= 1'b0;
            tries_q  <= '0;
        end else begin
            state    <= state_nx;
            lfsr     <= lfsr_nx;
            wait_cnt <= wait_nx;
            valid_q  <= valid_nx;
            data_q   <= data_nx;
            fail_q   <= fail_nx;
            tries_q  <= tries_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        lfsr_nx   = lfsr;
        wait_nx   = wait_cnt;
        valid_nx  = valid_q;
        data_nx   = data_q;
        fail_nx   = fail_q;
        tries_nx  = tries_q;
        tries_inc = tries_q + 16'd1;
        case (state)
            IDLE: begin
                // seed_load takes priority so a simultaneous start cannot run on a stale seed
                if (seed_load) begin
                    lfsr_nx = (seed == '0) ? ONE : seed;
                end else if (start) begin
                    tries_nx = '0;
                    fail_nx  = 1'b0;
                    wait_nx  = LAT;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (wait_cnt != '0) begin
                    wait_nx = wait_cnt - 4'd1;
                end else begin
                    tries_nx = tries_inc;
                    if (sat) begin
                        data_nx  = lfsr;
                        valid_nx = 1'b1;
                        state_nx = HOLD;
                    end else if (tries_inc == MAX_T) begin
                        fail_nx  = 1'b1;
                        lfsr_nx  = lfsr_step(lfsr);
                        state_nx = IDLE;
                    end else begin
                        lfsr_nx  = lfsr_step(lfsr);
                        wait_nx  = LAT;
                    end
                end
            end
            HOLD: begin
                // step past the accepted solution so the next search starts fresh
                if (sol_ready) begin
                    valid_nx = 1'b0;
                    lfsr_nx  = lfsr_step(lfsr);
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cand      = lfsr;
    assign sol_valid = valid_q;
    assign sol_data  = data_q;
    assign busy      = (state != IDLE);
    assign fail      = fail_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_constraint_sampler.sv
// tb/tb_constraint_sampler.sv - directed bench for constraint_sampler
// Two instances: CHECK_LAT=0 (d0) and CHECK_LAT=2 (d1), both W=8, POLY=B8, MAX_TRIES=4.
module tb_constraint_sampler;

    logic       clk;
    logic       rst;

    logic       start0, seed_load0, sol_ready0, sat_en0;
    logic [7:0] seed0, target0, cand0, sol_data0;
    logic       sat0, sol_valid0, busy0, fail0;
    logic [15:0] tries0;

    logic       start1, seed_load1, sol_ready1;
    logic [7:0] seed1, cand1, sol_data1;
    logic       sat1, sol_valid1, busy1, fail1;
    logic [15:0] tries1;

    int total = 0;
    int bad   = 0;

    constraint_sampler #(
        .W(8), .POLY(8'hB8), .SEED(8'h01), .MAX_TRIES(4), .CHECK_LAT(0)
    ) d0 (
        .clk(clk), .rst(rst), .start(start0), .seed_load(seed_load0), .seed(seed0),
        .cand(cand0), .sat(sat0), .sol_valid(sol_valid0), .sol_ready(sol_ready0),
        .sol_data(sol_data0), .busy(busy0), .fail(fail0), .tries(tries0)
    );

    constraint_sampler #(
        .W(8), .POLY(8'hB8), .SEED(8'h01), .MAX_TRIES(4), .CHECK_LAT(2)
    ) d1 (
        .clk(clk), .rst(rst), .start(start1), .seed_load(seed_load1), .seed(seed1),
        .cand(cand1), .sat(sat1), .sol_valid(sol_valid1), .sol_ready(sol_ready1),
        .sol_data(sol_data1), .busy(busy1), .fail(fail1), .tries(tries1)
    );

    // external checker models
    assign sat0 = sat_en0 && (cand0 == target0);
    assign sat1 = (cand1 == 8'h5C);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_d0(input logic [7:0] exp_cand, input string tag);
        chk({tag, ".cand"}, 32'(cand0), 32'(exp_cand));
        chk({tag, ".valid"}, 32'(sol_valid0), 32'd0);
        chk({tag, ".busy"}, 32'(busy0), 32'd0);
        chk({tag, ".fail"}, 32'(fail0), 32'd0);
        chk({tag, ".tries"}, 32'(tries0), 32'd0);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 0; seed_load0 = 0; sol_ready0 = 0; sat_en0 = 0; seed0 = 0; target0 = 8'h2E;
        start1 = 0; seed_load1 = 0; sol_ready1 = 0; seed1 = 0;

        // 1. reset values, then asynchronous reset after two attempts
        #12;
        idle_d0(8'h01, "rst");
        chk("rst.d1cand", 32'(cand1), 32'h01);
        chk("rst.d1busy", 32'(busy1), 32'd0);
        nxt(); rst = 1'b0;
        sat_en0 = 1; target0 = 8'h2E;
        nxt(); start0 = 1;
        nxt(); start0 = 0;
        chk("s1.cand0", 32'(cand0), 32'h01);
        nxt();
        nxt();
        chk("s1.tries2", 32'(tries0), 32'd2);
        chk("s1.cand2", 32'(cand0), 32'h5C);
        #2 rst = 1'b1;
        #1 idle_d0(8'h01, "s1async");
        nxt(); rst = 1'b0;

        // 2. success on the last allowed attempt
        nxt(); start0 = 1;
        nxt(); start0 = 0;
        chk("s2.c0", 32'(cand0), 32'h01);
        chk("s2.busy", 32'(busy0), 32'd1);
        nxt(); chk("s2.c1", 32'(cand0), 32'hB8);
        nxt(); chk("s2.c2", 32'(cand0), 32'h5C);
        nxt(); chk("s2.c3", 32'(cand0), 32'h2E);
        chk("s2.notyet", 32'(sol_valid0), 32'd0);
        chk("s2.tries3", 32'(tries0), 32'd3);
        nxt();
        chk("s2.valid", 32'(sol_valid0), 32'd1);
        chk("s2.data", 32'(sol_data0), 32'h2E);
        chk("s2.tries", 32'(tries0), 32'd4);
        chk("s2.fail", 32'(fail0), 32'd0);
        chk("s2.busy_h", 32'(busy0), 32'd1);

        // 4. backpressure: solution and candidate stable, start ignored in HOLD
        start0 = 1; seed_load0 = 1; seed0 = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("s4.valid", 32'(sol_valid0), 32'd1);
            chk("s4.data", 32'(sol_data0), 32'h2E);
            chk("s4.cand", 32'(cand0), 32'h2E);
        end
        start0 = 0; seed_load0 = 0;
        sol_ready0 = 1;
        nxt(); sol_ready0 = 0;
        chk("s4.valid0", 32'(sol_valid0), 32'd0);
        chk("s4.cand", 32'(cand0), 32'h17);
        chk("s4.busy", 32'(busy0), 32'd0);
        chk("s4.tries", 32'(tries0), 32'd4);

        // 5. seed handling and start ignored during CHECK
        sat_en0 = 0;
        seed_load0 = 1; seed0 = 8'h00;
        nxt();
        chk("s5.zero_seed", 32'(cand0), 32'h01);
        seed0 = 8'h5C; start0 = 1;
        nxt(); seed_load0 = 0;
        chk("s5.seed", 32'(cand0), 32'h5C);
        chk("s5.nobusy", 32'(busy0), 32'd0);
        nxt();
        chk("s5.busy", 32'(busy0), 32'd1);
        chk("s5.t0", 32'(tries0), 32'd0);
        nxt(); chk("s5.t1", 32'(tries0), 32'd1);
        nxt(); chk("s5.t2", 32'(tries0), 32'd2);
        chk("s5.cand", 32'(cand0), 32'h17);
        start0 = 0;
        #2 rst = 1'b1;
        nxt(); rst = 1'b0;

        // 3. exhaustion and restart from the stepped candidate
        start0 = 1;
        nxt(); start0 = 0;
        nxt(); nxt(); nxt();
        chk("s3.busy_pre", 32'(busy0), 32'd1);
        nxt();
        chk("s3.fail", 32'(fail0), 32'd1);
        chk("s3.busy", 32'(busy0), 32'd0);
        chk("s3.tries", 32'(tries0), 32'd4);
        chk("s3.cand", 32'(cand0), 32'h17);
        chk("s3.valid", 32'(sol_valid0), 32'd0);
        nxt();
        chk("s3.hold_tries", 32'(tries0), 32'd4);
        start0 = 1;
        nxt(); start0 = 0;
        chk("s3.fail_clr", 32'(fail0), 32'd0);
        chk("s3.tries_clr", 32'(tries0), 32'd0);
        chk("s3.cand_re", 32'(cand0), 32'h17);
        nxt();
        chk("s3.cand_nx", 32'(cand0), 32'hB3);
        chk("s3.tries1", 32'(tries0), 32'd1);

        // 6. CHECK_LAT=2: one decision every three cycles
        start1 = 1;
        nxt(); start1 = 0;
        for (int i = 0; i <= 9; i++) begin
            logic [7:0] ec;
            ec = (i < 3) ? 8'h01 : (i < 6) ? 8'hB8 : 8'h5C;
            chk($sformatf("s6.cand%0d", i), 32'(cand1), 32'(ec));
            chk($sformatf("s6.valid%0d", i), 32'(sol_valid1), (i == 9) ? 32'd1 : 32'd0);
            if (i < 9) nxt();
        end
        chk("s6.data", 32'(sol_data1), 32'h5C);
        chk("s6.tries", 32'(tries1), 32'd3);
        chk("s6.fail", 32'(fail1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
